// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input handshake plus instruction-memory write bus.
// master drives in_valid/in_data and observes the rest; slave (the loader)
// consumes bytes, reports in_ready and drives imem_we/imem_addr/imem_wdata.
interface prog_loader_if #(parameter int ADDR_W = 12);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  modport master (output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave (input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: assembles a big-endian byte stream into 16-bit words written to imem, checksum-gated core release.
// Ports: clk, rst (async, active-high), start (restart pulse from RUN/ERR),
// bus (byte stream in, imem write out), cpu_rst/done/error status.
module prog_loader #(
  parameter int ADDR_W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         done,
  output logic         error
);
  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, RUN, ERR} state_t;
  state_t            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, idx_q, idx_d;
  logic [15:0]       sum_q, sum_d, wdata_q, wdata_d, word;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, cpu_rst_q, cpu_rst_d, xfer, too_big;
  assign bus.in_ready   = state_q != RUN && state_q != ERR;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign done           = state_q == RUN;
  assign error          = state_q == ERR;
  assign xfer           = bus.in_valid && bus.in_ready;
  // byte_q holds whichever high byte is pending, so every 16-bit field is {byte_q, in_data}
  assign word           = {byte_q, bus.in_data};
  assign too_big        = {16'd0, word} > (32'd1 << ADDR_W);
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    case (state_q)
      CNT_HI, DATA_HI, SUM_HI: if (xfer) begin
        byte_d  = bus.in_data;
        state_d = state_q == CNT_HI ? CNT_LO : state_q == DATA_HI ? DATA_LO : SUM_LO;
      end
      CNT_LO: if (xfer) begin
        cnt_d   = (ADDR_W+1)'(word);
        state_d = too_big ? ERR : word == 16'd0 ? SUM_HI : DATA_HI;
      end
      DATA_LO: if (xfer) begin
        we_d    = 1'b1;
        addr_d  = idx_q[ADDR_W-1:0];
        wdata_d = word;
        sum_d   = sum_q + word;
        idx_d   = idx_q + 1'b1;
        state_d = idx_d == cnt_q ? SUM_HI : DATA_HI;
      end
      SUM_LO: if (xfer) begin
        state_d   = word == sum_q ? RUN : ERR;
        cpu_rst_d = word != sum_q;
      end
      RUN, ERR: if (start) begin
        state_d   = CNT_HI;
        cnt_d     = '0;
        idx_d     = '0;
        sum_d     = '0;
        cpu_rst_d = 1'b1;
      end
      default: state_d = CNT_HI;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CNT_HI;
      byte_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written to consecutive instruction-memory addresses starting at 0, and the image is checked against a trailing 16-bit checksum. The processor core is held in reset until a good image is loaded.

## Interface
Parameters:
- ADDR_W, 12: instruction-memory word-address width; the maximum image is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; restarts a load from RUN or ERR, ignored in other states.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte; combinational from state.
- imem_we  out  1  instruction-memory write enable, registered, one cycle per word.
- imem_addr  out  ADDR_W  write word address, registered.
- imem_wdata  out  16  write data, registered.
- cpu_rst  out  1  reset to the processor core, registered, active-high.
- done  out  1  high while in RUN.
- error  out  1  high while in ERR.

## Operation
- Stream format: count_hi, count_lo, then N words (each sent as hi byte then lo byte), then sum_hi, sum_lo. All multi-byte fields are big-endian.
- A byte transfers on any rising edge where in_valid && in_ready. Bytes presented while in_ready=0 are not consumed.
- FSM states: CNT_HI, CNT_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, RUN, ERR. The reset state is CNT_HI.
- in_ready is 1 in CNT_HI through SUM_LO, and 0 in RUN and ERR.
- CNT_HI → CNT_LO: latch the high byte of N.
- CNT_LO branches on N:
  - N > 2^ADDR_W → ERR.
  - N == 0 → SUM_HI.
  - Otherwise → DATA_HI.
- DATA_HI → DATA_LO: latch the high byte of the word.
- DATA_LO handles each completed word:
  - Issue the write: imem_wdata = {hi, lo}, imem_addr = word index, imem_we = 1.
  - Update the sum: sum = sum + word, modulo 2^16.
  - Increment the word index.
  - If the index reaches N → SUM_HI; otherwise → DATA_HI.
- SUM_HI → SUM_LO: latch the high byte of the expected checksum.
- SUM_LO compares {sum_hi, sum_lo} with the running sum:
  - Equal → RUN.
  - Unequal → ERR.
- RUN: cpu_rst = 0, done = 1. A start pulse → CNT_HI.
- ERR: cpu_rst = 1, error = 1. A start pulse → CNT_HI.
- On every entry to CNT_HI (reset or start), clear the word index, the running sum and the count register, and assert cpu_rst.
- Memory that an earlier load wrote beyond the new N is not cleared.
- Word index width is ADDR_W+1, so N = 2^ADDR_W is representable. The last word is written at address 2^ADDR_W−1, and imem_addr takes the low ADDR_W bits.

## Timing
- Reset values: in_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_rst = 1, done = 0, error = 0. State is CNT_HI.
- Reset is asynchronous: asserting rst mid-load immediately forces the reset values, abandons any partial image and holds cpu_rst high.
- Write latency: imem_we is high exactly in the cycle after the DATA_LO byte transfers, with imem_addr and imem_wdata valid in that same cycle. imem_we is 0 in all other cycles.
- Throughput is one byte per cycle, so back-to-back words produce imem_we every second cycle.
- cpu_rst falls, and done rises, on the edge at which the SUM_LO byte transfers with a matching checksum. The core therefore sees its first non-reset cycle one cycle after the final byte, and fetches from address 0.
- The final word's write (cycle after its DATA_LO) always precedes the cpu_rst release by at least 2 cycles.
- Stalls: in_valid=0 holds the state indefinitely with no side effects.
- start arriving on the same edge as a byte transfer in a loading state is ignored.
- rst takes precedence over start.

## Test plan
- Good image, ADDR_W=12:
  - Stimulus: bytes 00 02 | 12 34 | AB CD | BE 01 (sum 0x1234+0xABCD = 0xBE01), in_valid held high.
  - Required: writes (0, 0x1234) and (1, 0xABCD), two cycles apart.
  - Required: cpu_rst falls, and done rises, one cycle after the 0x01 byte; in_ready then goes 0.
- Bad checksum: same stream ending BE 02.
  - Required: both writes still occur; error = 1; cpu_rst stays 1; in_ready = 0.
  - Required: after a start pulse, state returns to CNT_HI and a correct reload reaches RUN.
- Empty and oversize counts:
  - Stream 00 00 00 00 → RUN with no imem_we.
  - With ADDR_W=4, count 00 11 (17) → ERR after the second byte.
  - With ADDR_W=4, count 00 10 (16) → 16 words written at addresses 0–15.
- Stalls: good image with in_valid toggled pseudo-randomly.
  - Required: identical write sequence and final state; no write in any cycle other than the one after a DATA_LO transfer.
- Reset mid-load: assert rst after the third data byte.
  - Required: all outputs return to reset values asynchronously, with no further imem_we.
  - Required: a fresh full image then loads correctly, starting at address 0.
